// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA front end, START/STOP detection, fixed
// 7-bit address match, write-byte reception and handshaked read-byte service.
// SDA is open-drain: sda_oe=1 pulls the line low, 0 releases it.
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_READ_ACK,
    S_IGNORE
  } state_t;

  // Synchroniser chains plus one delay flop each for edge detection.
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_on_q, ack_on_d;     // set once the ACK slot drive has begun
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic [7:0] byte_in;

  // Resynchronise the pins; reset to the idle-bus level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
      sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  // SDA edges only count as START/STOP while SCL is stably high.
  assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

  // Protocol state register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      ack_on_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ack_on_q   <= ack_on_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: STOP and START override every state, then per-state bit handling.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ack_on_d   = ack_on_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    byte_in    = {shift_q[6:0], sda_s};

    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_on_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      sda_oe_d  = 1'b0;
      ack_on_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sda_oe_d = 1'b0;
        end

        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (byte_in[7:1] == ADDR) begin
                state_d = S_ADDR_ACK;
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
              end else begin
                state_d = S_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        S_ADDR_ACK, S_WRITE_ACK: begin
          // For a read, the first byte is fetched on the ACK rising edge.
          if (scl_rise && state_q == S_ADDR_ACK && rw_q) begin
            tx_req_d = 1'b1;
            shift_d  = tx_data;
          end
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                sda_oe_d = ~shift_q[7];
                state_d  = S_READ;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = S_WRITE;
              end
            end
          end
        end

        S_WRITE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              state_d    = S_WRITE_ACK;
            end
          end
        end

        S_READ: begin
          // shift_q[7] always holds the bit to present on the next falling edge.
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = S_READ_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end

        S_READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d  = 1'b1;
              shift_d   = tx_data;
              bit_cnt_d = 4'd0;
              state_d   = S_READ;
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end

        S_IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign rw       = rw_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bus-master model drives SCL/SDA, the
// open-drain line is modelled as master AND NOT sda_oe, and received write
// bytes are checked through a scoreboard queue.
module tb_i2c_target;

  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       rw;
  logic       busy;
  wire        sda_line = sda_m & ~sda_oe;

  int n_checks = 0;
  int n_pass   = 0;
  int rx_cnt   = 0;
  int tx_cnt   = 0;
  logic [7:0] rx_exp_q[$];

  always #5 clk = ~clk;

  i2c_target #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .rw       (rw),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard side: every rx_valid pulse pops the next expected byte.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      check("rx_expected_pending", 32'(rx_exp_q.size() > 0), 32'd1);
      if (rx_exp_q.size() > 0) begin
        logic [7:0] e;
        e = rx_exp_q.pop_front();
        check("rx_byte", 32'(rx_data), 32'(e));
        $display("rx byte 0x%02h expected 0x%02h", rx_data, e);
      end
    end
    if (tx_req) begin
      tx_cnt++;
      $display("tx_req: tx_data 0x%02h", tx_data);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b0; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic send_bit(input logic b, output logic line, output logic oe);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    line = sda_line;
    oe   = sda_oe;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack, output logic ack_oe,
                            output logic data_oe);
    logic l, o;
    data_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i], l, o);
      data_oe |= o;
    end
    send_bit(1'b1, l, o);
    ack    = ~l;
    ack_oe = o;
    $display("write 0x%02h ack=%0b", d, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic l, o;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, l, o);
      d[i] = l;
    end
    send_bit(~master_ack, l, o);
    $display("read 0x%02h master_ack=%0b", d, master_ack);
  endtask

  initial begin
    logic       ack, aoe, doe, l, o;
    logic [7:0] d;
    int         rx_base, tx_base;

    scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00; reset = 1'b1;
    wait_clk(4);
    check("rst_sda_oe",   32'(sda_oe),   32'd0);
    check("rst_rx_data",  32'(rx_data),  32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_req",   32'(tx_req),   32'd0);
    check("rst_rw",       32'(rw),       32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    reset = 1'b0;
    wait_clk(4);

    // 1: addressed write of one byte
    rx_base = rx_cnt;
    i2c_start();
    write_byte(8'h84, ack, aoe, doe);
    check("t1_addr_ack",    32'(ack), 32'd1);
    check("t1_addr_ack_oe", 32'(aoe), 32'd1);
    check("t1_addr_bit_oe", 32'(doe), 32'd0);
    check("t1_busy",        32'(busy), 32'd1);
    check("t1_rw",          32'(rw), 32'd0);
    rx_exp_q.push_back(8'hA5);
    write_byte(8'hA5, ack, aoe, doe);
    check("t1_data_ack_oe", 32'(aoe), 32'd1);
    check("t1_data_bit_oe", 32'(doe), 32'd0);
    check("t1_busy_pre_stop", 32'(busy), 32'd1);
    i2c_stop();
    wait_clk(4);
    check("t1_busy_post_stop", 32'(busy), 32'd0);
    check("t1_rx_pulses", 32'(rx_cnt - rx_base), 32'd1);
    check("t1_rx_data", 32'(rx_data), 32'hA5);

    // 2: wrong address, never acknowledged
    rx_base = rx_cnt;
    i2c_start();
    write_byte(8'h86, ack, aoe, doe);
    check("t2_addr_nack", 32'(ack), 32'd0);
    check("t2_addr_oe",   32'(aoe | doe), 32'd0);
    check("t2_busy",      32'(busy), 32'd0);
    write_byte(8'h11, ack, aoe, doe);
    check("t2_data_oe",   32'(ack | aoe | doe), 32'd0);
    i2c_stop();
    wait_clk(4);
    check("t2_rx_pulses", 32'(rx_cnt - rx_base), 32'd0);
    check("t2_busy_end",  32'(busy), 32'd0);

    // 3: read two bytes, ACK then NACK
    tx_base = tx_cnt;
    tx_data = 8'h3C;
    i2c_start();
    write_byte(8'h85, ack, aoe, doe);
    check("t3_addr_ack", 32'(ack), 32'd1);
    check("t3_rw",       32'(rw), 32'd1);
    check("t3_busy",     32'(busy), 32'd1);
    tx_data = 8'hC3;
    read_byte(1'b1, d);
    check("t3_byte0", 32'(d), 32'h3C);
    read_byte(1'b0, d);
    check("t3_byte1", 32'(d), 32'hC3);
    check("t3_oe_after_nack",   32'(sda_oe), 32'd0);
    check("t3_busy_after_nack", 32'(busy), 32'd0);
    check("t3_tx_req_pulses",   32'(tx_cnt - tx_base), 32'd2);
    i2c_stop();
    wait_clk(4);

    // 4: partial byte cut by repeated START
    rx_base = rx_cnt;
    i2c_start();
    write_byte(8'h84, ack, aoe, doe);
    check("t4_addr_ack", 32'(ack), 32'd1);
    send_bit(1'b1, l, o);
    send_bit(1'b0, l, o);
    send_bit(1'b1, l, o);
    send_bit(1'b0, l, o);
    i2c_start();
    check("t4_partial_pulses", 32'(rx_cnt - rx_base), 32'd0);
    write_byte(8'h84, ack, aoe, doe);
    check("t4_readdr_ack", 32'(ack), 32'd1);
    rx_exp_q.push_back(8'h5A);
    write_byte(8'h5A, ack, aoe, doe);
    check("t4_data_ack", 32'(ack), 32'd1);
    i2c_stop();
    wait_clk(4);
    check("t4_rx_pulses", 32'(rx_cnt - rx_base), 32'd1);
    check("t4_rx_data",   32'(rx_data), 32'h5A);

    // 5: reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h84;
      send_bit(d[i], l, o);
    end
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    check("t5_oe_before_reset",   32'(sda_oe), 32'd1);
    check("t5_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    wait_clk(1);
    check("t5_oe_after_reset",   32'(sda_oe), 32'd0);
    check("t5_busy_after_reset", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
    i2c_stop();
    wait_clk(4);
    rx_base = rx_cnt;
    i2c_start();
    write_byte(8'h84, ack, aoe, doe);
    check("t5_addr_ack", 32'(ack), 32'd1);
    rx_exp_q.push_back(8'h77);
    write_byte(8'h77, ack, aoe, doe);
    check("t5_data_ack", 32'(ack), 32'd1);
    i2c_stop();
    wait_clk(4);
    check("t5_rx_pulses", 32'(rx_cnt - rx_base), 32'd1);
    check("t5_rx_data",   32'(rx_data), 32'h77);

    // 6: STOP after three data bits
    rx_base = rx_cnt;
    i2c_start();
    write_byte(8'h84, ack, aoe, doe);
    check("t6_addr_ack", 32'(ack), 32'd1);
    send_bit(1'b1, l, o);
    send_bit(1'b1, l, o);
    send_bit(1'b0, l, o);
    i2c_stop();
    wait_clk(4);
    check("t6_rx_pulses", 32'(rx_cnt - rx_base), 32'd0);
    check("t6_busy",      32'(busy), 32'd0);
    check("t6_sda_oe",    32'(sda_oe), 32'd0);

    wait_clk(10);
    check("scoreboard_drained", 32'(rx_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
